// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM encodings,
// ASCII constants used by the byte producers, and a ceil(log2) helper.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_DONE = 2'd1,
      ST_GAP       = 2'd2
   } arb_state_e;

   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if (int'(32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set bit of full_mask found by
// searching upward from last_grant+1 with wrap-around.
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    full_mask,
   input  logic [ID_W-1:0] last_grant,
   output logic [ID_W-1:0] grant,
   output logic            valid
);

   int   dist_s;
   int   best_dist_s;
   logic take_s;

   // Keep the candidate with the smallest rotated distance from last_grant+1
   always_comb begin
      grant       = last_grant;
      valid       = 1'b0;
      best_dist_s = N;
      dist_s      = 0;
      take_s      = 1'b0;
      for (int i = 0; i < N; i++) begin
         // Offset by 2*N keeps the dividend positive for any last_grant value
         dist_s      = (i + 2 * N - 1 - int'(last_grant)) % N;
         take_s      = full_mask[i] && (dist_s < best_dist_s);
         best_dist_s = take_s ? dist_s : best_dist_s;
         grant       = take_s ? ID_W'(i) : grant;
         valid       = valid | take_s;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers. Each producer has a
// one-deep holding slot; a round-robin FSM launches one frame per byte,
// waits for tx_done (guarded by a watchdog) and enforces an idle gap.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int GAP_CYCLES  = 16,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_dv,
   input  logic [8*NUM_REQ-1:0]       req_byte,
   output logic [NUM_REQ-1:0]         req_busy,
   input  logic                       tx_active,
   input  logic                       tx_done,
   output logic                       tx_dv,
   output logic [7:0]                 tx_byte,
   output logic [clog2(NUM_REQ)-1:0]  grant_id,
   output logic [NUM_REQ-1:0]         overflow,
   output logic                       timeout_err
);

   localparam int ID_W  = clog2(NUM_REQ);
   localparam int GAP_W = clog2(GAP_CYCLES + 1);
   localparam int WD_W  = clog2(TIMEOUT_CYC + 1);

   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

   arb_state_e           state_r;
   arb_state_e           state_s;
   logic [GAP_W-1:0]     gap_cnt_r;
   logic [GAP_W-1:0]     gap_cnt_s;
   logic [WD_W-1:0]      wd_cnt_r;
   logic [WD_W-1:0]      wd_cnt_s;
   logic [NUM_REQ-1:0]   slot_full_r;
   logic [7:0]           slot_byte_r [NUM_REQ];
   logic [NUM_REQ-1:0]   release_s;
   logic                 tx_dv_s;
   logic [7:0]           tx_byte_s;
   logic [ID_W-1:0]      grant_id_s;
   logic                 timeout_s;
   logic [ID_W-1:0]      pick_id_s;
   logic                 pick_vld_s;

   assign req_busy = slot_full_r;

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .full_mask  (slot_full_r),
      .last_grant (grant_id),
      .grant      (pick_id_s),
      .valid      (pick_vld_s)
   );

   // Next-state, counter and output decode for the arbitration FSM
   always_comb begin
      state_s    = state_r;
      gap_cnt_s  = gap_cnt_r;
      wd_cnt_s   = wd_cnt_r;
      tx_dv_s    = 1'b0;
      tx_byte_s  = tx_byte;
      grant_id_s = grant_id;
      timeout_s  = 1'b0;
      release_s  = '0;
      case (state_r)
         ST_IDLE: begin
            if (pick_vld_s && !tx_active) begin
               tx_dv_s    = 1'b1;
               tx_byte_s  = slot_byte_r[pick_id_s];
               grant_id_s = pick_id_s;
               wd_cnt_s   = '0;
               state_s    = ST_WAIT_DONE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               release_s[grant_id] = 1'b1;
               wd_cnt_s            = '0;
               gap_cnt_s           = '0;
               state_s             = ST_GAP;
            end else if (wd_cnt_r == WD_LAST) begin
               // tx_done never came: drop the byte so the other slots keep moving
               release_s[grant_id] = 1'b1;
               timeout_s           = 1'b1;
               wd_cnt_s            = '0;
               gap_cnt_s           = '0;
               state_s             = ST_GAP;
            end else begin
               wd_cnt_s = wd_cnt_r + WD_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
               gap_cnt_s = '0;
               state_s   = ST_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r + GAP_W'(1);
            end
         end
         default: begin
            gap_cnt_s = '0;
            wd_cnt_s  = '0;
            state_s   = ST_IDLE;
         end
      endcase
   end

   // FSM state, counters and registered uart_tx-facing outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         gap_cnt_r   <= '0;
         wd_cnt_r    <= '0;
         tx_dv       <= 1'b0;
         tx_byte     <= 8'h00;
         grant_id    <= ID_LAST;
         timeout_err <= 1'b0;
      end else begin
         state_r     <= state_s;
         gap_cnt_r   <= gap_cnt_s;
         wd_cnt_r    <= wd_cnt_s;
         tx_dv       <= tx_dv_s;
         tx_byte     <= tx_byte_s;
         grant_id    <= grant_id_s;
         timeout_err <= timeout_s;
      end
   end

   // Holding slots: load on req_dv, free on release, flag drops as overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_full_r <= '0;
         overflow    <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_byte_r[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_dv[i]) begin
               // A slot being released this cycle accepts the new byte directly
               if (!slot_full_r[i] || release_s[i]) begin
                  slot_full_r[i] <= 1'b1;
                  slot_byte_r[i] <= req_byte[8*i +: 8];
               end else begin
                  overflow[i] <= 1'b1;
               end
            end else if (release_s[i]) begin
               slot_full_r[i] <= 1'b0;
            end else begin
               slot_full_r[i] <= slot_full_r[i];
            end
         end
      end
   end

endmodule
